contador_bcd_n: RTL and testbench

//  - Parametrised N-digit BCD up/down counter; successor to the fixed 2-digit 0-99 counter.
//  - Adds per-cycle enable, programmable maximum, parallel load, saturate/wrap mode,

---
 rtl/contador_bcd_n_pkg.sv | 35 +++
 rtl/contador_bcd_n_digito_bcd.sv | 43 ++++
 rtl/contador_bcd_n.sv | 141 ++++++++++++++
 tb/tb_contador_bcd_n.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/contador_bcd_n_pkg.sv
// Shared definitions for the N-digit BCD counter.
//  - BCD digit width and largest legal digit value
//  - action_e: the single action chosen for the count register each cycle
//  - is_valid_bcd(): true when every nibble of a (zero-extended) vector is 0-9
package contador_bcd_n_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  // Widest vector is_valid_bcd() accepts; callers zero-extend to this width.
  localparam int         BCD_VEC_MAX_W = 64;

  typedef enum logic [2:0] {
    ACT_HOLD     = 3'd0,
    ACT_LOAD     = 3'd1,
    ACT_LOAD_ERR = 3'd2,
    ACT_CLEAR    = 3'd3,
    ACT_REFILL   = 3'd4,
    ACT_STEP     = 3'd5
  } action_e;

  // Zero nibbles are valid BCD, so zero-extension never changes the result.
  function automatic logic is_valid_bcd(input logic [BCD_VEC_MAX_W-1:0] vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_VEC_MAX_W / BCD_DIGIT_W; i++) begin
      if (vec[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/contador_bcd_n_digito_bcd.sv
// One BCD digit of the ripple step chain (purely combinational).
//  digit      in  4  current digit value
//  inc        in  1  1 = add, 0 = subtract
//  step_in    in  1  carry (up) / borrow (down) from the lower digit
//  next_digit out 4  digit after the step
//  step_out   out 1  carry / borrow into the next higher digit
module digito_bcd
  import contador_bcd_n_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  input  logic                   inc,
  input  logic                   step_in,
  output logic [BCD_DIGIT_W-1:0] next_digit,
  output logic                   step_out
);

  // Add or subtract step_in with decimal roll-over at 9 / 0.
  always_comb begin
    next_digit = digit;
    step_out   = 1'b0;
    if (!step_in) begin
      next_digit = digit;
      step_out   = 1'b0;
    end else if (inc) begin
      if (digit >= BCD_MAX_DIGIT) begin
        next_digit = 4'd0;
        step_out   = 1'b1;
      end else begin
        next_digit = digit + 4'd1;
        step_out   = 1'b0;
      end
    end else begin
      if (digit == 4'd0) begin
        next_digit = BCD_MAX_DIGIT;
        step_out   = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
        step_out   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/contador_bcd_n.sv
// Parametrised N-digit BCD up/down counter with load, saturate/wrap,
// auto-refill below a threshold and terminal/wrap flags.
//  clock, reset          rising-edge clock, synchronous active-high reset
//  en, inc               step qualifier and direction (1 = up)
//  saturate              1 = hold at bounds, 0 = wrap
//  auto_repor            refill to REFILL_BCD while count < THRESH_BCD
//  reset_no_max          clear to 0 while count == MAX_BCD
//  load, load_val        parallel load (rejected if not BCD or > MAX_BCD)
//  count                 registered BCD value, digit 0 in the LS nibble
//  at_max, at_zero       decoded from count
//  wrapped, load_err     registered one-cycle pulses
module contador_bcd_n
  import contador_bcd_n_pkg::*;
#(
  parameter int                  DIGITS     = 2,
  parameter logic [4*DIGITS-1:0] MAX_BCD    = (4*DIGITS)'(8'h99),
  parameter logic [4*DIGITS-1:0] REFILL_BCD = (4*DIGITS)'(8'h25),
  parameter logic [4*DIGITS-1:0] THRESH_BCD = (4*DIGITS)'(8'h05)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  inc,
  input  logic                  saturate,
  input  logic                  auto_repor,
  input  logic                  reset_no_max,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  wrapped,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    count_r;
  logic            wrapped_r;
  logic            load_err_r;
  logic [W-1:0]    step_val_s;
  logic [DIGITS:0] chain_s;
  logic            at_max_s;
  logic            at_zero_s;
  logic            load_ok_s;
  logic            underflow_s;
  action_e         action_s;
  logic [W-1:0]    next_count_s;
  logic            next_wrapped_s;
  logic            next_load_err_s;

  // The LS digit always receives the unit step; carries/borrows ripple upward.
  assign chain_s[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    digito_bcd u_digit (
      .digit      (count_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .inc        (inc),
      .step_in    (chain_s[g]),
      .next_digit (step_val_s[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .step_out   (chain_s[g+1])
    );
  end

  assign at_max_s    = (count_r == MAX_BCD);
  assign at_zero_s   = (count_r == {W{1'b0}});
  // A borrow out of the MS digit on a down step happens only from all-zero.
  assign underflow_s = !inc && chain_s[DIGITS];
  // Digits are checked first, so a plain binary compare orders BCD values correctly.
  assign load_ok_s   = is_valid_bcd(BCD_VEC_MAX_W'(load_val)) && (load_val <= MAX_BCD);

  // Pick exactly one action, highest priority first (reset is applied in the register).
  always_comb begin
    action_s = ACT_HOLD;
    if (load) begin
      action_s = load_ok_s ? ACT_LOAD : ACT_LOAD_ERR;
    end else if (reset_no_max && at_max_s) begin
      action_s = ACT_CLEAR;
    end else if (auto_repor && (count_r < THRESH_BCD)) begin
      action_s = ACT_REFILL;
    end else if (en) begin
      action_s = ACT_STEP;
    end else begin
      action_s = ACT_HOLD;
    end
  end

  // Next count and flag pulses for the chosen action, including bound handling.
  always_comb begin
    next_count_s    = count_r;
    next_wrapped_s  = 1'b0;
    next_load_err_s = 1'b0;
    case (action_s)
      ACT_LOAD:     next_count_s = load_val;
      ACT_LOAD_ERR: next_load_err_s = 1'b1;
      ACT_CLEAR:    next_count_s = {W{1'b0}};
      ACT_REFILL:   next_count_s = REFILL_BCD;
      ACT_STEP: begin
        if (inc && at_max_s) begin
          // Exact match on MAX_BCD, so non-99 maxima (e.g. 59) bound correctly.
          if (saturate) begin
            next_count_s = count_r;
          end else begin
            next_count_s   = {W{1'b0}};
            next_wrapped_s = 1'b1;
          end
        end else if (underflow_s) begin
          if (saturate) begin
            next_count_s = count_r;
          end else begin
            next_count_s   = MAX_BCD;
            next_wrapped_s = 1'b1;
          end
        end else begin
          next_count_s = step_val_s;
        end
      end
      default:      next_count_s = count_r;
    endcase
  end

  // Count register and pulse flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r    <= {W{1'b0}};
      wrapped_r  <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= next_count_s;
      wrapped_r  <= next_wrapped_s;
      load_err_r <= next_load_err_s;
    end
  end

  assign count    = count_r;
  assign at_max   = at_max_s;
  assign at_zero  = at_zero_s;
  assign wrapped  = wrapped_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_contador_bcd_n.sv
// Self-checking bench for contador_bcd_n: directed scenarios plus randomized
// stimulus against a decimal-integer reference model. Two instances are used:
// MAX_BCD='h99 and MAX_BCD='h59, sharing all inputs.
module tb_contador_bcd_n;

  logic       clock = 1'b0;
  logic       reset, en, inc, saturate, auto_repor, reset_no_max, load;
  logic [7:0] load_val;
  logic [7:0] count99, count59;
  logic       at_max99, at_zero99, wrapped99, load_err99;
  logic       at_max59, at_zero59, wrapped59, load_err59;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain decimal values plus expected pulses.
  int m99 = 0, m59 = 0;
  bit ew99, el99, ew59, el59;

  always #5 clock = ~clock;

  contador_bcd_n #(.DIGITS(2), .MAX_BCD(8'h99), .REFILL_BCD(8'h25), .THRESH_BCD(8'h05)) dut99 (
    .clock(clock), .reset(reset), .en(en), .inc(inc), .saturate(saturate),
    .auto_repor(auto_repor), .reset_no_max(reset_no_max), .load(load), .load_val(load_val),
    .count(count99), .at_max(at_max99), .at_zero(at_zero99), .wrapped(wrapped99), .load_err(load_err99));

  contador_bcd_n #(.DIGITS(2), .MAX_BCD(8'h59), .REFILL_BCD(8'h25), .THRESH_BCD(8'h05)) dut59 (
    .clock(clock), .reset(reset), .en(en), .inc(inc), .saturate(saturate),
    .auto_repor(auto_repor), .reset_no_max(reset_no_max), .load(load), .load_val(load_val),
    .count(count59), .at_max(at_max59), .at_zero(at_zero59), .wrapped(wrapped59), .load_err(load_err59));

  function automatic bit valid_bcd(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  function automatic int bcd2int(input logic [7:0] v);
    return 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    int t, u;
    t = v / 10;
    u = v % 10;
    return {t[3:0], u[3:0]};
  endfunction

  // Next decimal value from the rule list, highest priority first.
  function automatic int model_next(input int maxv, input int v, output bit wr, output bit le);
    int lv;
    wr = 1'b0;
    le = 1'b0;
    if (reset) return 0;
    if (load) begin
      lv = bcd2int(load_val);
      if (valid_bcd(load_val) && lv <= maxv) return lv;
      le = 1'b1;
      return v;
    end
    if (reset_no_max && v == maxv) return 0;
    if (auto_repor && v < 5) return 25;
    if (en) begin
      if (inc) begin
        if (v < maxv) return v + 1;
        if (saturate) return v;
        wr = 1'b1;
        return 0;
      end else begin
        if (v > 0) return v - 1;
        if (saturate) return v;
        wr = 1'b1;
        return maxv;
      end
    end
    return v;
  endfunction

  task automatic tick();
    m99 = model_next(99, m99, ew99, el99);
    m59 = model_next(59, m59, ew59, el59);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; en = 1'b0; inc = 1'b0; saturate = 1'b0;
    auto_repor = 1'b0; reset_no_max = 1'b0; load = 1'b0; load_val = 8'h00;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (count99 !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", count99); end
    checks++; if (wrapped99 !== 1'b0 || load_err99 !== 1'b0) begin errors++; $display("FAIL reset_flags got w=%b e=%b want 0 0", wrapped99, load_err99); end
    checks++; if (at_zero99 !== 1'b1 || at_max99 !== 1'b0) begin errors++; $display("FAIL reset_decode got z=%b m=%b want 1 0", at_zero99, at_max99); end
  endtask

  task automatic test_count_up_wrap();
    int wraps = 0;
    idle_inputs();
    en = 1'b1; inc = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (wrapped99 === 1'b1) wraps++;
      checks++;
      if (count99 !== int2bcd(i % 100) || wrapped99 !== (i == 100)) begin
        errors++;
        $display("FAIL up_wrap step %0d got %h w=%b want %h w=%b", i, count99, wrapped99, int2bcd(i % 100), (i == 100));
      end
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL up_wrap_once got %0d pulses want 1", wraps); end
  endtask

  task automatic test_count_down();
    idle_inputs();
    do_load(8'h10);
    en = 1'b1; inc = 1'b0;
    tick();
    checks++; if (count99 !== 8'h09) begin errors++; $display("FAIL down_borrow got %h want 09", count99); end
    tick();
    checks++; if (count99 !== 8'h08) begin errors++; $display("FAIL down_step got %h want 08", count99); end
    do_load(8'h00);
    tick();
    checks++; if (count99 !== 8'h99 || wrapped99 !== 1'b1) begin errors++; $display("FAIL down_wrap got %h w=%b want 99 w=1", count99, wrapped99); end
    do_load(8'h00);
    saturate = 1'b1;
    tick();
    checks++; if (count99 !== 8'h00 || wrapped99 !== 1'b0) begin errors++; $display("FAIL down_sat got %h w=%b want 00 w=0", count99, wrapped99); end
  endtask

  task automatic test_saturate_clear();
    idle_inputs();
    do_load(8'h99);
    en = 1'b1; inc = 1'b1; saturate = 1'b1;
    tick();
    checks++; if (count99 !== 8'h99 || at_max99 !== 1'b1 || wrapped99 !== 1'b0) begin errors++; $display("FAIL up_sat got %h m=%b w=%b want 99 1 0", count99, at_max99, wrapped99); end
    reset_no_max = 1'b1;
    tick();
    checks++; if (count99 !== 8'h00 || at_zero99 !== 1'b1) begin errors++; $display("FAIL clear_at_max got %h want 00", count99); end
  endtask

  task automatic test_refill();
    idle_inputs();
    do_load(8'h03);
    auto_repor = 1'b1;
    tick();
    checks++; if (count99 !== 8'h25) begin errors++; $display("FAIL refill got %h want 25", count99); end
    tick();
    checks++; if (count99 !== 8'h25) begin errors++; $display("FAIL refill_above got %h want 25", count99); end
    en = 1'b1; inc = 1'b1;
    tick();
    checks++; if (count99 !== 8'h26) begin errors++; $display("FAIL refill_then_step got %h want 26", count99); end
  endtask

  task automatic test_load_err();
    idle_inputs();
    do_load(8'h42);
    do_load(8'h3A);
    checks++; if (count99 !== 8'h42 || load_err99 !== 1'b1) begin errors++; $display("FAIL load_bad_digit got %h e=%b want 42 e=1", count99, load_err99); end
    tick();
    checks++; if (load_err99 !== 1'b0) begin errors++; $display("FAIL load_err_pulse got %b want 0", load_err99); end
    do_load(8'h60);
    checks++; if (count59 !== 8'h42 || load_err59 !== 1'b1) begin errors++; $display("FAIL load_above_max59 got %h e=%b want 42 e=1", count59, load_err59); end
    checks++; if (count99 !== 8'h60 || load_err99 !== 1'b0) begin errors++; $display("FAIL load_ok_max99 got %h e=%b want 60 e=0", count99, load_err99); end
  endtask

  task automatic test_reset_override();
    idle_inputs();
    do_load(8'h47);
    en = 1'b1; inc = 1'b1; reset = 1'b1; load = 1'b1; load_val = 8'h12;
    tick();
    checks++; if (count99 !== 8'h00) begin errors++; $display("FAIL reset_override got %h want 00", count99); end
    reset = 1'b0; load = 1'b0;
    tick();
    checks++; if (count99 !== 8'h01) begin errors++; $display("FAIL resume_1 got %h want 01", count99); end
    tick();
    checks++; if (count99 !== 8'h02) begin errors++; $display("FAIL resume_2 got %h want 02", count99); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 59) == 0);
      load         = ($urandom_range(0, 7) == 0);
      load_val     = ($urandom_range(0, 1) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 99));
      en           = ($urandom_range(0, 3) != 0);
      inc          = $urandom_range(0, 1) == 1;
      saturate     = $urandom_range(0, 1) == 1;
      auto_repor   = ($urandom_range(0, 5) == 0);
      reset_no_max = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (count99 !== int2bcd(m99) || at_max99 !== (m99 == 99) || at_zero99 !== (m99 == 0) ||
          wrapped99 !== ew99 || load_err99 !== el99) begin
        errors++;
        $display("FAIL rand99 cyc %0d got %h m%b z%b w%b e%b want %h m%b z%b w%b e%b", c,
                 count99, at_max99, at_zero99, wrapped99, load_err99,
                 int2bcd(m99), (m99 == 99), (m99 == 0), ew99, el99);
      end
      checks++;
      if (count59 !== int2bcd(m59) || at_max59 !== (m59 == 59) || at_zero59 !== (m59 == 0) ||
          wrapped59 !== ew59 || load_err59 !== el59) begin
        errors++;
        $display("FAIL rand59 cyc %0d got %h m%b z%b w%b e%b want %h m%b z%b w%b e%b", c,
                 count59, at_max59, at_zero59, wrapped59, load_err59,
                 int2bcd(m59), (m59 == 59), (m59 == 0), ew59, el59);
      end
    end
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_count_up_wrap();
    test_count_down();
    test_saturate_clear();
    test_refill();
    test_load_err();
    test_reset_override();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
